// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if : host byte stream and CPU instruction-fetch port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;

   modport master (
      output start, in_valid, in_data, imem_addr,
      input  in_ready, imem_data
   );

   modport slave (
      input  start, in_valid, in_data, imem_addr,
      output in_ready, imem_data
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : 256x8 instruction array with checksummed host loader
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter logic [7:0] NOP_WORD    = 8'hC0,
   parameter bit         CHECKSUM_EN = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       areset,
   imem_loader_if.slave    bus,
   output logic            cpu_run,
   output logic            busy,
   output logic            err,
   output logic [8:0]      prog_len
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_LOAD  = 3'd2,
      S_CKSUM = 3'd3,
      S_RUN   = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_nxt;
   logic       r_in_ready;
   logic [7:0] r_wptr;
   logic [7:0] r_sum;
   logic [8:0] r_len;
   logic [7:0] r_mem [256];

   logic       w_xfer;
   logic       w_last;
   logic       w_nxt_busy;

   assign w_xfer = bus.in_valid && r_in_ready;
   // len==256 finishes when wptr reaches 255, so compare in 9 bits
   assign w_last = ({1'b0, r_wptr} == (r_len - 9'd1));

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_RUN, S_ERR: begin
            if (bus.start) w_nxt = S_HDR;
         end
         S_HDR: begin
            if (w_xfer) w_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (w_xfer && w_last) w_nxt = CHECKSUM_EN ? S_CKSUM : S_RUN;
         end
         S_CKSUM: begin
            if (w_xfer) w_nxt = (bus.in_data == r_sum) ? S_RUN : S_ERR;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   assign w_nxt_busy = (w_nxt == S_HDR) || (w_nxt == S_LOAD) || (w_nxt == S_CKSUM);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         busy       <= 1'b0;
         cpu_run    <= 1'b0;
         err        <= 1'b0;
         prog_len   <= 9'd0;
         r_wptr     <= 8'd0;
         r_sum      <= 8'd0;
         r_len      <= 9'd0;
      end else begin
         r_state    <= w_nxt;
         r_in_ready <= w_nxt_busy;
         busy       <= w_nxt_busy;
         cpu_run    <= (w_nxt == S_RUN);
         err        <= (w_nxt == S_ERR);

         case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
               if (bus.start) begin
                  r_wptr <= 8'd0;
                  r_sum  <= 8'd0;
               end
            end
            S_HDR: begin
               if (w_xfer) r_len <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            end
            S_LOAD: begin
               if (w_xfer) begin
                  r_wptr <= r_wptr + 8'd1;
                  r_sum  <= r_sum + bus.in_data;
               end
            end
            default: ;
         endcase

         if (w_nxt == S_RUN && r_state != S_RUN) prog_len <= r_len;
         else if (w_nxt == S_ERR && r_state != S_ERR) prog_len <= 9'd0;
      end
   end

   // Array is not reset; unloaded contents stay hidden behind prog_len
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && w_xfer) r_mem[r_wptr] <= bus.in_data;
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.imem_data = (cpu_run && ({1'b0, bus.imem_addr} < prog_len))
                          ? r_mem[bus.imem_addr] : NOP_WORD;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed self-checking bench for imem_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

   logic clk;
   logic areset;
   int   checks;
   int   errors;

   imem_loader_if bus  ();
   imem_loader_if bus2 ();

   logic       cpu_run,  busy,  err;
   logic [8:0] prog_len;
   logic       cpu_run2, busy2, err2;
   logic [8:0] prog_len2;

   imem_loader #(.NOP_WORD(8'hC0), .CHECKSUM_EN(1'b1)) dut (
      .clk(clk), .areset(areset), .bus(bus),
      .cpu_run(cpu_run), .busy(busy), .err(err), .prog_len(prog_len)
   );

   imem_loader #(.NOP_WORD(8'hC0), .CHECKSUM_EN(1'b0)) dut2 (
      .clk(clk), .areset(areset), .bus(bus2),
      .cpu_run(cpu_run2), .busy(busy2), .err(err2), .prog_len(prog_len2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit sel, input logic [7:0] b);
      int n;
      @(negedge clk);
      if (sel) begin bus2.in_valid = 1'b1; bus2.in_data = b; end
      else     begin bus.in_valid  = 1'b1; bus.in_data  = b; end
      n = 0;
      while (((sel ? bus2.in_ready : bus.in_ready) !== 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high byte=%h", b);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus2.in_valid = 1'b0;
   endtask

   task automatic pulse_start(input bit sel, input bit with_valid);
      @(negedge clk);
      if (sel) begin bus2.start = 1'b1; bus2.in_valid = with_valid; bus2.in_data = 8'h02; end
      else     begin bus.start  = 1'b1; bus.in_valid  = with_valid; bus.in_data  = 8'h02; end
      @(posedge clk);
      #1;
      bus.start  = 1'b0; bus.in_valid  = 1'b0;
      bus2.start = 1'b0; bus2.in_valid = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
      bus.imem_addr = a;
      #1;
      chk(tag, {8'h00, bus.imem_data}, {8'h00, e});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      areset = 1'b0;
      bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.imem_addr = 8'h00;
      bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.imem_addr = 8'h00;
      repeat (3) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);

      // Reset state
      rd("rst_data", 8'h00, 8'hC0);
      chk("rst_cpu_run",  {15'd0, cpu_run},       16'd0);
      chk("rst_in_ready", {15'd0, bus.in_ready},  16'd0);
      chk("rst_busy",     {15'd0, busy},          16'd0);
      chk("rst_prog_len", {7'd0, prog_len},       16'd0);

      // Good 3-byte load; byte offered with start must be ignored
      pulse_start(1'b0, 1'b1);
      chk("hdr_busy",     {15'd0, busy},         16'd1);
      chk("hdr_in_ready", {15'd0, bus.in_ready}, 16'd1);
      send(1'b0, 8'd3);
      send(1'b0, 8'hC4);
      send(1'b0, 8'hD1);
      send(1'b0, 8'h3F);
      send(1'b0, 8'hD4);
      chk("good_cpu_run",  {15'd0, cpu_run}, 16'd1);
      chk("good_prog_len", {7'd0, prog_len}, 16'd3);
      chk("good_busy",     {15'd0, busy},    16'd0);
      rd("good_addr0", 8'h00, 8'hC4);
      rd("good_addr1", 8'h01, 8'hD1);
      rd("good_addr2", 8'h02, 8'h3F);
      rd("good_addr3", 8'h03, 8'hC0);

      // Restart from RUN with a concurrent byte, then a bad checksum
      bus.imem_addr = 8'h02;
      pulse_start(1'b0, 1'b1);
      chk("rerun_cpu_run", {15'd0, cpu_run}, 16'd0);
      chk("rerun_busy",    {15'd0, busy},    16'd1);
      chk("rerun_data",    {8'h00, bus.imem_data}, 16'h00C0);
      send(1'b0, 8'd3);
      send(1'b0, 8'hC4);
      pulse_start(1'b0, 1'b0);
      chk("midload_busy", {15'd0, busy}, 16'd1);
      send(1'b0, 8'hD1);
      send(1'b0, 8'h3F);
      send(1'b0, 8'hD5);
      chk("bad_err",      {15'd0, err},     16'd1);
      chk("bad_cpu_run",  {15'd0, cpu_run}, 16'd0);
      chk("bad_prog_len", {7'd0, prog_len}, 16'd0);
      chk("bad_busy",     {15'd0, busy},    16'd0);
      rd("bad_addr0", 8'h00, 8'hC0);

      // Full 256-byte load
      pulse_start(1'b0, 1'b0);
      chk("restart_err", {15'd0, err}, 16'd0);
      send(1'b0, 8'h00);
      for (int i = 0; i < 256; i++) send(1'b0, i[7:0]);
      send(1'b0, 8'h80);
      chk("full_cpu_run",  {15'd0, cpu_run}, 16'd1);
      chk("full_prog_len", {7'd0, prog_len}, 16'd256);
      rd("full_addrFF", 8'hFF, 8'hFF);
      rd("full_addr00", 8'h00, 8'h00);
      for (int i = 0; i < 256; i++) rd("full_sweep", i[7:0], i[7:0]);

      // Reset partway through a 5-byte load
      pulse_start(1'b0, 1'b0);
      send(1'b0, 8'd5);
      send(1'b0, 8'hAA);
      send(1'b0, 8'hBB);
      @(negedge clk);
      areset = 1'b0;
      #1;
      chk("arst_busy",     {15'd0, busy},         16'd0);
      chk("arst_prog_len", {7'd0, prog_len},      16'd0);
      chk("arst_cpu_run",  {15'd0, cpu_run},      16'd0);
      chk("arst_in_ready", {15'd0, bus.in_ready}, 16'd0);
      @(negedge clk);
      areset = 1'b1;

      // Fresh load with a stalled host in the middle
      pulse_start(1'b0, 1'b0);
      send(1'b0, 8'd2);
      send(1'b0, 8'h11);
      repeat (10) @(negedge clk);
      chk("stall_busy",     {15'd0, busy},         16'd1);
      chk("stall_in_ready", {15'd0, bus.in_ready}, 16'd1);
      chk("stall_cpu_run",  {15'd0, cpu_run},      16'd0);
      send(1'b0, 8'h22);
      send(1'b0, 8'h33);
      chk("fresh_cpu_run",  {15'd0, cpu_run}, 16'd1);
      chk("fresh_prog_len", {7'd0, prog_len}, 16'd2);
      rd("fresh_addr1", 8'h01, 8'h22);
      rd("fresh_addr2", 8'h02, 8'hC0);

      // No checksum phase: RUN right after the last data byte
      pulse_start(1'b1, 1'b0);
      send(1'b1, 8'd2);
      send(1'b1, 8'hAA);
      chk("nock_busy_mid", {15'd0, busy2}, 16'd1);
      send(1'b1, 8'hBB);
      chk("nock_cpu_run",  {15'd0, cpu_run2}, 16'd1);
      chk("nock_prog_len", {7'd0, prog_len2}, 16'd2);
      chk("nock_busy",     {15'd0, busy2},    16'd0);
      bus2.imem_addr = 8'h01;
      #1;
      chk("nock_addr1", {8'h00, bus2.imem_data}, 16'h00BB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Responder side of the CPU instruction-fetch interface. Owns a 256x8 instruction array and serves `imem_addr` to `imem_data`.
- Also contains a host-side loader. A host streams a program into the array over a valid/ready byte interface, and the block holds the CPU in reset until a verified load completes.
- Sits between the testbench/host and `cpu`. Its `cpu_run` output drives the CPU's `areset`.

Parameters:
- NOP_WORD, 8'hC0, instruction returned for unloaded addresses and while the CPU is held (arith op 00 = NOP).
- CHECKSUM_EN, 1, 1: a checksum byte follows the data; 0: no checksum phase.

Ports:
- clk  input  1  system clock, rising edge.
- areset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a new load.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  block accepts a byte this cycle.
- imem_addr  input  8  CPU fetch address.
- imem_data  output  8  instruction for imem_addr (combinational).
- cpu_run  output  1  0 holds the CPU in reset; 1 releases it.
- busy  output  1  load in progress (HDR/LOAD/CKSUM).
- err  output  1  last load failed its checksum.
- prog_len  output  9  accepted program length, 0..256.

Behaviour:
- Reset (areset=0, async):
  - state=IDLE; cpu_run=0, err=0, busy=0, in_ready=0.
  - prog_len=0, internal wptr=0, sum=0.
  - Array contents are not reset; they are masked because prog_len=0.
- Transfer rule: a byte transfers on a rising edge with in_valid&&in_ready. in_ready is registered-state decoded: 1 only in HDR, LOAD, CKSUM.
- State IDLE:
  - start -> HDR; clear err, wptr, sum.
  - in_ready=0, so in_valid is ignored, including in the same cycle as start.
- State HDR: on transfer, len = (in_data==0) ? 256 : in_data. Go to LOAD.
- State LOAD:
  - On transfer: mem[wptr]<=in_data; sum<=sum+in_data (mod 256); wptr++.
  - On the transfer of byte number len: go to CKSUM if CHECKSUM_EN, else to RUN.
- State CKSUM: on transfer, compare in_data against sum.
  - Equal -> RUN; prog_len<=len.
  - Unequal -> ERR; prog_len<=0.
- State RUN:
  - cpu_run=1, asserted from the first cycle in RUN.
  - start -> HDR; cpu_run falls on the next edge and the CPU is held from then on.
- State ERR:
  - err=1, cpu_run=0.
  - start -> HDR, which clears err.
- busy = state in {HDR, LOAD, CKSUM}. start during busy is ignored.
- Read port:
  - Outside RUN: imem_data=NOP_WORD.
  - In RUN: imem_data = (imem_addr < prog_len) ? mem[imem_addr] : NOP_WORD.
  - Zero-latency combinational read, matching the single-cycle fetch.
- Write/read same address: impossible by construction, since no reads are served while loading.
- Length 256: wptr wraps 255->0 on the final byte and must not write a 257th byte. prog_len=256 makes every address valid.
- A stalled host (in_valid=0) keeps the current state indefinitely. There is no timeout.
- Reset mid-load: returns to IDLE with cpu_run=0. Any partially written bytes are unreachable because prog_len=0.

Test Plan:
- Reset, then fetch addr 8'h00 -> imem_data=8'hC0, cpu_run=0, in_ready=0.
- start; send len=3, data C4,D1,3F, cksum=0xD4 (C4+D1+3F mod 256) -> RUN.
  - cpu_run=1; prog_len=3.
  - addr1 -> D1; addr3 -> C0.
- Same load with cksum=0xD5 -> ERR: err=1, cpu_run=0, prog_len=0, addr0 -> C0.
  - A following start clears err.
- len byte 0x00 followed by 256 bytes value i, plus the correct cksum (0x80) -> prog_len=256.
  - addr FF -> FF; addr 00 -> 00; exactly 256 array writes.
- In RUN, pulse start together with in_valid=1 -> no byte is accepted that cycle; cpu_run=0 after the edge; busy=1.
  - Also: a start pulse during LOAD is ignored and the load completes normally.
- Assert areset after 2 of 5 data bytes -> IDLE, busy=0, prog_len=0.
  - A fresh complete load then succeeds.
  - Extra case: with CHECKSUM_EN=0 and len=2 -> RUN immediately after the 2nd byte.
